// File: rtl/dmem_access_unit.sv
// dmem_access_unit: single-outstanding load/store unit between the core's
// execute stage and a 32-word, word-write data memory. Sub-word stores are
// performed as a read-modify-write.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW
// complete with resp_err=1 and no memory access. When undefined, the low
// address bits are forced to alignment and the access proceeds.
module dmem_access_unit #(
    parameter int unsigned WORD_IDX_W = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        WE,
    output logic [31:0] A_DM,
    output logic [31:0] WD,
    input  logic [31:0] RD3
);

    localparam int unsigned AW = WORD_IDX_W + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [AW-1:0]   r_addr;
    logic [2:0]      r_funct3;
    logic [31:0]     r_wdata;
    logic [31:0]     r_merge;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misalign;
    logic            w_err;
    logic [AW-1:0]   w_addr;
    logic [4:0]      w_shamt;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load_ext;
    logic [31:0]     w_mask;
    logic [31:0]     w_wd;
    logic            w_unused;

    // Only the word-index and lane bits of the byte address are ever used.
    assign w_unused = ^req_addr[31:AW];

    assign w_accept = (r_state == IDLE) && req_valid;

    // Request decode: illegal funct3 and alignment of the incoming address.
    always_comb begin
        w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        w_addr     = req_addr[AW-1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        w_err      = w_illegal || w_misalign;
`else
        w_err      = w_illegal;
        if (req_funct3[1:0] == 2'b01) begin
            w_addr[0] = 1'b0;
        end else if (req_funct3 == 3'b010) begin
            w_addr[1:0] = 2'b00;
        end
`endif
    end

    // Lane selection for loads and lane merge for sub-word stores.
    always_comb begin
        w_shamt   = {r_addr[1:0], 3'b000};
        w_shifted = RD3 >> w_shamt;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_ext = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_ext = {16'h0000, w_shifted[15:0]};
            default: w_load_ext = RD3;
        endcase
        if (r_funct3[1:0] == 2'b00) begin
            w_mask = 32'h0000_00FF << w_shamt;
        end else begin
            w_mask = 32'h0000_FFFF << w_shamt;
        end
        if (r_funct3 == 3'b010) begin
            w_wd = r_wdata;
        end else begin
            w_wd = (r_merge & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next = DONE;
                    end else if (!req_we) begin
                        w_next = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        w_next = WRITE;
                    end else begin
                        w_next = RMW_RD;
                    end
                end
            end
            LOAD:    w_next = DONE;
            RMW_RD:  w_next = WRITE;
            WRITE:   w_next = DONE;
            DONE:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, load result capture and RMW merge buffer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= w_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                r_rdata  <= '0;
                r_err    <= w_err;
            end
            if (r_state == LOAD) begin
                r_rdata <= w_load_ext;
            end
            if (r_state == RMW_RD) begin
                r_merge <= RD3;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign WE         = (r_state == WRITE);
    assign A_DM       = (r_state == IDLE) ? '0
                        : {{(32-WORD_IDX_W){1'b0}}, r_addr[AW-1:2]};
    assign WD         = (r_state == IDLE) ? '0 : w_wd;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with a 32-word memory
// model whose every word starts at 0x0000000A.
module tb_dmem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        WE;
    logic [31:0] A_DM;
    logic [31:0] WD;
    logic [31:0] RD3;

    logic [31:0] mem [32] = '{default: 32'h0000000A};
    int          we_count = 0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_a = '0;

    int n_checks = 0;
    int n_fail = 0;

    dmem_access_unit #(.WORD_IDX_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .WE(WE), .A_DM(A_DM), .WD(WD), .RD3(RD3)
    );

    always #5 CLK = ~CLK;

    assign RD3 = mem[A_DM[4:0]];

    always @(posedge CLK) begin
        if (WE) begin
            mem[A_DM[4:0]] <= WD;
            we_count = we_count + 1;
            last_wd  = WD;
            last_a   = A_DM;
        end
    end

    // Issue one request, measure edges from accept to resp_valid, then retire it.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd,
                          output logic err);
        @(negedge CLK);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_wdata = 32'h1357_9BDF;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge CLK);
            #1;
            lat = lat + 1;
        end
        rd  = resp_rdata;
        err = resp_err;
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
        n_checks++; if (WE !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", WE); end
        n_checks++; if (A_DM !== 32'h0) begin n_fail++; $display("FAIL rst_a_dm: got %h want 0", A_DM); end
        n_checks++; if (WD !== 32'h0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", WD); end
    endtask

    task automatic test_lw_initial;
        int lat; logic [31:0] rd; logic err;
        do_req(1'b0, 3'b010, 32'h08, 32'h0, lat, rd, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_checks++; if (rd !== 32'h0000000A) begin n_fail++; $display("FAIL lw_rdata: got %h want 0000000a", rd); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", err); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_back_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_sw_loads;
        int lat; logic [31:0] rd; logic err; int wc;
        logic [2:0]  f3s [4];
        logic [31:0] exps [4];
        f3s[0] = 3'b000; exps[0] = 32'hFFFFFF81;
        f3s[1] = 3'b100; exps[1] = 32'h00000081;
        f3s[2] = 3'b001; exps[2] = 32'hFFFFFF81;
        f3s[3] = 3'b101; exps[3] = 32'h0000FF81;
        wc = we_count;
        do_req(1'b1, 3'b010, 32'h10, 32'h8000_FF81, lat, rd, err);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_checks++; if (we_count !== wc + 1) begin n_fail++; $display("FAIL sw_we_pulses: got %0d want %0d", we_count - wc, 1); end
        n_checks++; if (last_wd !== 32'h8000_FF81) begin n_fail++; $display("FAIL sw_wd: got %h want 8000ff81", last_wd); end
        n_checks++; if (last_a !== 32'd4) begin n_fail++; $display("FAIL sw_a_dm: got %h want 4", last_a); end
        n_checks++; if (rd !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, err); end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], 32'h10, 32'h0, lat, rd, err);
            n_checks++; if (rd !== exps[i] || err !== 1'b0) begin n_fail++; $display("FAIL subword_load_f3_%0d: got %h/%b want %h/0", f3s[i], rd, err, exps[i]); end
        end
    endtask

    task automatic test_sb_rmw;
        int lat; logic [31:0] rd; logic err; int wc;
        wc = we_count;
        do_req(1'b1, 3'b000, 32'h13, 32'hCCCC_CC5A, lat, rd, err);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
        n_checks++; if (we_count !== wc + 1) begin n_fail++; $display("FAIL sb_we_pulses: got %0d want 1", we_count - wc); end
        n_checks++; if (last_wd !== 32'h5A00_FF81) begin n_fail++; $display("FAIL sb_wd: got %h want 5a00ff81", last_wd); end
        n_checks++; if (last_a !== 32'd4) begin n_fail++; $display("FAIL sb_a_dm: got %h want 4", last_a); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err);
        n_checks++; if (rd !== 32'h5A00FF81) begin n_fail++; $display("FAIL sb_readback: got %h want 5a00ff81", rd); end
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, err);
        n_checks++; if (rd !== 32'h0000005A) begin n_fail++; $display("FAIL lb_lane3: got %h want 0000005a", rd); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, err);
        n_checks++; if (rd !== 32'h00005A00) begin n_fail++; $display("FAIL lh_upper: got %h want 00005a00", rd); end
        do_req(1'b1, 3'b001, 32'h0E, 32'h0000_BEEF, lat, rd, err);
        n_checks++; if (last_wd !== 32'hBEEF_000A || lat !== 3) begin n_fail++; $display("FAIL sh_upper_wd: got %h lat %0d want beef000a lat 3", last_wd, lat); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic err; int wc;
        logic [2:0] f3s [3];
        logic       wes [3];
        f3s[0] = 3'b011; wes[0] = 1'b0;
        f3s[1] = 3'b100; wes[1] = 1'b1;
        f3s[2] = 3'b111; wes[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wc = we_count;
            do_req(wes[i], f3s[i], 32'h10, 32'hFFFF_FFFF, lat, rd, err);
            n_checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || we_count !== wc) begin
                n_fail++; $display("FAIL illegal_%0d: got lat %0d err %b rd %h we %0d want lat 1 err 1 rd 0 we 0", i, lat, err, rd, we_count - wc);
            end
        end
    endtask

    task automatic test_misalign;
        int lat; logic [31:0] rd; logic err; int wc;
        wc = we_count;
        do_req(1'b0, 3'b010, 32'h06, 32'h0, lat, rd, err);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_checks++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lw_misalign: got lat %0d err %b rd %h want 1/1/0", lat, err, rd); end
        do_req(1'b1, 3'b001, 32'h11, 32'h1234, lat, rd, err);
        n_checks++; if (lat !== 1 || err !== 1'b1 || we_count !== wc) begin n_fail++; $display("FAIL sh_misalign: got lat %0d err %b we %0d want 1/1/0", lat, err, we_count - wc); end
`else
        n_checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h0000000A) begin n_fail++; $display("FAIL lw_misalign: got lat %0d err %b rd %h want 2/0/0000000a", lat, err, rd); end
        do_req(1'b0, 3'b101, 32'h13, 32'h0, lat, rd, err);
        n_checks++; if (err !== 1'b0 || rd !== 32'h00005A00) begin n_fail++; $display("FAIL lhu_misalign: got err %b rd %h want 0/00005a00", err, rd); end
`endif
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic err;
        do_req(1'b1, 3'b010, 32'h84, 32'h1234_5678, lat, rd, err);
        n_checks++; if (last_a !== 32'd1) begin n_fail++; $display("FAIL wrap_a_dm: got %h want 1", last_a); end
        do_req(1'b0, 3'b010, 32'h04, 32'h0, lat, rd, err);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wrap_readback: got %h want 12345678", rd); end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h10;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(posedge CLK); #1; n++; end
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait: got resp_valid %b want 1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000FF81 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v %b rd %h rdy %b want 1/0000ff81/0", i, resp_valid, resp_rdata, req_ready);
            end
            @(posedge CLK);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        resp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rdy %b v %b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_rst_mid_rmw;
        int wc;
        wc = we_count;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h0000_BEEF;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        n_checks++; if (A_DM !== 32'd8 || WE !== 1'b0) begin n_fail++; $display("FAIL rmw_rd_phase: got a %h we %b want 8/0", A_DM, WE); end
        #1;
        RST = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || WE !== 1'b0 || A_DM !== 32'h0 || WD !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got rdy %b v %b we %b a %h wd %h rd %h err %b want reset values", req_ready, resp_valid, WE, A_DM, WD, resp_rdata, resp_err);
        end
        @(posedge CLK);
        #1;
        n_checks++; if (we_count !== wc || mem[8] !== 32'h0000000A) begin n_fail++; $display("FAIL rst_mid_no_write: got we %0d mem %h want 0/0000000a", we_count - wc, mem[8]); end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++; if (req_ready !== 1'b1 || WE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_recover: got rdy %b we %b want 1/0", req_ready, WE); end
    endtask

    initial begin
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK);
        RST = 1'b1;
        test_lw_initial();
        test_sw_loads();
        test_sb_rmw();
        test_errors();
        test_misalign();
        test_wrap();
        test_backpressure();
        test_rst_mid_rmw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Initiator-side load/store unit that sits between the core's execute stage and the 32-word data memory. It accepts one request at a time from the core over a valid/ready handshake and drives the memory's WE/A_DM/WD port, sampling RD3. It supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores are done as a read-modify-write, because the memory only writes whole words.

## Interface
- WORD_IDX_W, 5: width of the word index driven on A_DM; A_DM[31:WORD_IDX_W] is always 0.
- CLK  in  1  rising-edge clock, shared with the data memory.
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  response held until resp_ready.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access error, qualified by resp_valid.
- WE  out  1  memory write enable.
- A_DM  out  32  memory word index = req_addr[WORD_IDX_W+1:2], zero-extended.
- WD  out  32  memory write data.
- RD3  in  32  memory combinational read data for A_DM.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE: req_ready=1. On req_valid, the unit latches addr, funct3, we and wdata, then branches:
  - error → DONE, no memory access;
  - load → LOAD;
  - SW → WRITE;
  - SB/SH → RMW_RD.
- LOAD: A_DM is driven. At the clock edge, RD3 is sampled, the byte or half is selected by addr[1:0], and the result is sign- or zero-extended per funct3 into resp_rdata. Next state: DONE.
- RMW_RD: A_DM is driven, WE=0. RD3 is captured into the merge buffer. Next state: WRITE.
- WRITE: WE=1 for exactly one cycle. WD = wdata for SW, or the merge buffer with the byte/half replaced at lane addr[1:0] for SB/SH. Next state: DONE.
- DONE: resp_valid=1. The unit stays here until resp_ready=1, then returns to IDLE. No back-to-back acceptance from DONE.
- Errors:
  - funct3 of 011, 110 or 111 (any, or 100/101 with req_we=1) sets resp_err=1 in every build.
  - Misalignment handling is described under Configuration.
- WE is 0 in every state except WRITE. A_DM and WD hold their latched values outside IDLE and are 0 in IDLE.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, WE=0, A_DM=0, WD=0.
- Reset is asynchronous: asserting RST mid-access forces IDLE immediately. WE drops in the same cycle, so no partial RMW write occurs. Any pending response is discarded.
- Latency from the accepting edge to the first cycle with resp_valid=1:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- The accepting edge is the rising edge where req_valid && req_ready. Request fields are ignored outside that edge.
- resp_rdata and resp_err stay stable while resp_valid=1 && resp_ready=0.
- Address wrap: the word index uses only bits [WORD_IDX_W+1:2]. Address 0x80 aliases word 0.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, completes with resp_err=1;
  - no memory access is made and WE is never asserted.
- DMEM_MISALIGN_TRAP_EN undefined:
  - low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=00) and the access proceeds normally;
  - resp_err is set only for illegal funct3.

## Test plan
- LW at byte address 0x08, memory freshly reset so every word is 0x0000000A → resp_valid 2 cycles after accept, resp_rdata=0x0000000A, resp_err=0.
- SW 0x8000_FF81 to 0x10, then LB/LBU/LH/LHU at 0x10 → 0xFFFFFF81, 0x00000081, 0xFFFFFF81, 0x0000FF81.
- SB 0x5A at 0x13 over word 0x8000_FF81 → one RMW_RD cycle, then one WE pulse with WD=0x5A00_FF81; a following LW at 0x10 returns 0x5A00FF81.
- LW at 0x06:
  - with DMEM_MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, WE never high;
  - without it: reads word index 1 with resp_err=0.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0; release → IDLE next cycle.
- Assert RST during the RMW_RD of an SH → WE stays 0, target word unchanged, outputs at reset values.
